// File: rtl/mvau_stream_acc_out_pkg.sv
// Shared definitions for the MVAU stream accumulator: default lane width, lane type and
// a generic sign-extension helper usable at any operand width.
package mvau_defn;

    localparam int unsigned EXT_W      = 64;
    localparam int unsigned TO_DEFAULT = 24;

    typedef logic signed [TO_DEFAULT-1:0] acc_t;

    // Sign-extend the low w bits of v to EXT_W bits; callers truncate to their lane width.
    function automatic logic [EXT_W-1:0] sext(input logic [EXT_W-1:0] v, input int unsigned w);
        logic [EXT_W-1:0] r;
        logic [5:0]       sb;
        sb = 6'(w - 1);
        for (int i = 0; i < EXT_W; i++) begin
            r[i] = (i < int'(w)) ? v[i] : v[sb];
        end
        return r;
    endfunction

endpackage

// File: rtl/mvau_stream_acc_out_lane.sv
// One PE lane: sign-extends the partial product, accumulates modulo 2^TO and registers
// the finished dot product on the last beat.
module mvau_stream_acc_lane
    import mvau_defn::*;
#(
    parameter int unsigned DP_W = 16,
    parameter int unsigned TO   = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v,
    input  logic            first,
    input  logic            last,
    input  logic [DP_W-1:0] dp,
    output logic [TO-1:0]   out
);

    logic [TO-1:0] acc_q;
    logic [TO-1:0] out_q;
    logic [TO-1:0] dp_ext;
    logic [TO-1:0] sum;

    assign dp_ext = TO'(sext(EXT_W'(dp), DP_W));
    assign sum    = (first ? '0 : acc_q) + dp_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else if (v) begin
            acc_q <= sum;
            if (last) begin
                out_q <= sum;
            end
        end
    end

    assign out = out_q;

endmodule

// File: rtl/mvau_stream_acc_out.sv
// MVAU output accumulator: realigns control to the multiplier latency, accumulates
// per-PE partial sums over SF beats and flags framing errors.
module mvau_stream_acc_out
    import mvau_defn::*;
#(
    parameter int unsigned PE      = 2,
    parameter int unsigned SF      = 8,
    parameter int unsigned DP_W    = 16,
    parameter int unsigned TO      = TO_DEFAULT,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               do_mvau_stream,
    input  logic               sf_clr,
    input  logic [PE*DP_W-1:0] dp_in,
    output logic               out_v,
    output logic [PE*TO-1:0]   out,
    output logic               err
);

    localparam int unsigned CNT_W = (SF > 1) ? $clog2(SF) : 1;

    logic             v_dly;
    logic             last_dly;
    logic             first_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             out_v_q;
    logic             cnt_last;

    if (MUL_LAT == 0) begin : g_no_dly
        assign v_dly    = do_mvau_stream;
        assign last_dly = sf_clr;
    end else begin : g_dly
        logic [MUL_LAT-1:0] v_sr_q;
        logic [MUL_LAT-1:0] last_sr_q;

        // Concatenate-then-truncate shifts in the new bit and works for MUL_LAT == 1.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_sr_q    <= '0;
                last_sr_q <= '0;
            end else begin
                v_sr_q    <= MUL_LAT'({v_sr_q, do_mvau_stream});
                last_sr_q <= MUL_LAT'({last_sr_q, sf_clr});
            end
        end

        assign v_dly    = v_sr_q[MUL_LAT-1];
        assign last_dly = last_sr_q[MUL_LAT-1];
    end

    assign cnt_last = (cnt_q == CNT_W'(SF - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            out_v_q <= 1'b0;
        end else begin
            out_v_q <= v_dly && last_dly;
            if (v_dly) begin
                first_q <= last_dly;
                cnt_q   <= (last_dly || cnt_last) ? '0 : cnt_q + CNT_W'(1);
                if (last_dly != cnt_last) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    for (genvar p = 0; p < PE; p++) begin : g_lane
        mvau_stream_acc_lane #(
            .DP_W (DP_W),
            .TO   (TO)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .v     (v_dly),
            .first (first_q),
            .last  (last_dly),
            .dp    (dp_in[p*DP_W +: DP_W]),
            .out   (out[p*TO +: TO])
        );
    end

    assign out_v = out_v_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mvau_stream_acc_out.sv
// Randomised scoreboard bench for mvau_stream_acc_out, plus a narrow-width instance
// for modular wrap-around.
module tb_mvau_stream_acc_out;

    localparam int unsigned PE = 2;
    localparam int unsigned SF = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned TW = 24;
    localparam int unsigned ML = 2;

    typedef struct {
        int unsigned     cyc;
        logic [PE*TW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic do_mvau_stream = 1'b0;
    logic sf_clr = 1'b0;
    logic [PE*DW-1:0] dp_in = '0;
    logic dut_out_v;
    logic [PE*TW-1:0] dut_out;
    logic dut_err;

    logic w_v = 1'b0;
    logic w_last = 1'b0;
    logic [7:0] w_dp = '0;
    logic w_out_v;
    logic [7:0] w_out;
    logic w_err;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    exp_t exp_q[$];
    logic [PE*TW-1:0] hold_exp = '0;
    logic [PE*DW-1:0] dp_sr[0:ML];
    int beats0[$];
    int beats1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mvau_stream_acc_out #(
        .PE(PE), .SF(SF), .DP_W(DW), .TO(TW), .MUL_LAT(ML)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .do_mvau_stream (do_mvau_stream),
        .sf_clr         (sf_clr),
        .dp_in          (dp_in),
        .out_v          (dut_out_v),
        .out            (dut_out),
        .err            (dut_err)
    );

    mvau_stream_acc_out #(
        .PE(1), .SF(2), .DP_W(8), .TO(8), .MUL_LAT(0)
    ) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .do_mvau_stream (w_v),
        .sf_clr         (w_last),
        .dp_in          (w_dp),
        .out_v          (w_out_v),
        .out            (w_out),
        .err            (w_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // Monitor: every out_v must match the oldest expectation, at the predicted cycle.
    always @(negedge clk) begin
        exp_t e;
        if (dut_out_v) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_v actual=%h cyc=%0d required=none", dut_out, cyc);
            end else begin
                e = exp_q.pop_front();
                if (dut_out !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL out_vec actual=%h@%0d required=%h@%0d",
                             dut_out, cyc, e.data, e.cyc);
                end
                hold_exp = e.data;
            end
        end else begin
            checks++;
            if (dut_out !== hold_exp) begin
                errors++;
                $display("FAIL out_hold actual=%h required=%h", dut_out, hold_exp);
            end
        end
    end

    // Drive one control cycle; data follows ML cycles later. The model records each accepted
    // beat and, on sf_clr, predicts the plain integer sum reduced modulo 2^TW.
    task automatic step(input logic v, input logic last, input logic [15:0] d0,
                        input logic [15:0] d1);
        int s0;
        int s1;
        exp_t e;
        @(posedge clk); #1;
        do_mvau_stream = v;
        sf_clr = last;
        for (int i = ML; i > 0; i--) dp_sr[i] = dp_sr[i-1];
        dp_sr[0] = {d1, d0};
        dp_in = dp_sr[ML];
        if (v) begin
            beats0.push_back(int'($signed(d0)));
            beats1.push_back(int'($signed(d1)));
            if (last) begin
                s0 = 0;
                s1 = 0;
                foreach (beats0[i]) s0 += beats0[i];
                foreach (beats1[i]) s1 += beats1[i];
                e.cyc = cyc + ML + 1;
                e.data = {TW'(s1), TW'(s0)};
                exp_q.push_back(e);
                beats0.delete();
                beats1.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic drain(input string name);
        idle(ML + 3);
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic vec(input int gap_max, input logic [15:0] d0[4], input logic [15:0] d1[4]);
        for (int b = 0; b < 4; b++) begin
            step(1'b1, b == 3, d0[b], d1[b]);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        do_mvau_stream = 1'b0;
        sf_clr = 1'b0;
        beats0.delete();
        beats1.delete();
        for (int i = 0; i <= ML; i++) dp_sr[i] = '0;
        @(posedge clk); #1;
        hold_exp = '0;
        @(negedge clk);
        chk("rst_out", 64'(dut_out), 64'd0);
        chk("rst_err", 64'(dut_err), 64'd0);
        chk("rst_out_v", 64'(dut_out_v), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a0[4];
        logic [15:0] a1[4];
        for (int i = 0; i <= ML; i++) dp_sr[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_out", 64'(dut_out), 64'd0);
        chk("init_out_v", 64'(dut_out_v), 64'd0);
        chk("init_err", 64'(dut_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // 1..4 against -1 x4
        a0 = '{16'd1, 16'd2, 16'd3, 16'd4};
        a1 = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vec(0, a0, a1);
        drain("drain_a");
        chk("vecA_lane0", 64'(dut_out[TW-1:0]), 64'd10);
        chk("vecA_lane1", 64'(dut_out[2*TW-1:TW]), 64'hFFFFFC);
        chk("vecA_err", 64'(dut_err), 64'd0);

        // Back-to-back: 1..4 then 5 x4 with no bubble
        vec(0, a0, a1);
        a0 = '{16'd5, 16'd5, 16'd5, 16'd5};
        vec(0, a0, a1);
        drain("drain_b");
        chk("vecB_lane0", 64'(dut_out[TW-1:0]), 64'd20);

        // Random data, random 0-3 cycle gaps
        for (int n = 0; n < 20; n++) begin
            for (int b = 0; b < 4; b++) begin
                a0[b] = 16'($urandom);
                a1[b] = 16'($urandom);
            end
            vec(3, a0, a1);
        end
        drain("drain_rand");
        chk("rand_err", 64'(dut_err), 64'd0);

        // Framing: sf_clr on beat 2 still completes a 2-beat sum, then err sticks
        step(1'b1, 1'b0, 16'd7, 16'd1);
        step(1'b1, 1'b1, 16'd8, 16'd2);
        drain("drain_frame");
        chk("frame_lane0", 64'(dut_out[TW-1:0]), 64'd15);
        chk("frame_err", 64'(dut_err), 64'd1);
        a0 = '{16'd1, 16'd1, 16'd1, 16'd1};
        vec(1, a0, a0);
        drain("drain_frame2");
        chk("frame_err_sticky", 64'(dut_err), 64'd1);
        do_reset();
        chk("err_cleared", 64'(dut_err), 64'd0);

        // Reset with two beats still in flight, then a clean vector of ones
        step(1'b1, 1'b0, 16'd9, 16'd9);
        step(1'b1, 1'b0, 16'd9, 16'd9);
        do_reset();
        vec(0, a0, a0);
        drain("drain_midrst");
        chk("midrst_lane0", 64'(dut_out[TW-1:0]), 64'd4);
        chk("midrst_lane1", 64'(dut_out[2*TW-1:TW]), 64'd4);
        chk("midrst_err", 64'(dut_err), 64'd0);

        // 8-bit wrap instance, SF=2, no multiplier latency
        @(posedge clk); #1;
        w_v = 1'b1; w_last = 1'b0; w_dp = 8'd127;
        @(posedge clk); #1;
        w_last = 1'b1; w_dp = 8'd127;
        @(negedge clk);
        chk("wrap_no_early_v", 64'(w_out_v), 64'd0);
        @(posedge clk); #1;
        w_v = 1'b0; w_last = 1'b0; w_dp = 8'h55;
        @(negedge clk);
        chk("wrap_v", 64'(w_out_v), 64'd1);
        chk("wrap_out", 64'(w_out), 64'hFE);
        @(posedge clk); #1;
        w_v = 1'b1; w_last = 1'b0; w_dp = 8'h80;
        @(negedge clk);
        chk("wrap_pulse_once", 64'(w_out_v), 64'd0);
        chk("wrap_hold", 64'(w_out), 64'hFE);
        @(posedge clk); #1;
        w_last = 1'b1; w_dp = 8'hFF;
        @(posedge clk); #1;
        w_v = 1'b0; w_last = 1'b0;
        @(negedge clk);
        chk("wrap_neg_out", 64'(w_out), 64'h7F);
        chk("wrap_err", 64'(w_err), 64'd0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvau_stream_acc_out.md
Name: mvau_stream_acc_out

Overview:
- Downstream of the MVAU stream control unit and the SIMD multiply/adder-tree stage.
- Accumulates per-PE partial dot products over SF chunks, one chunk per cycle.
- Emits one registered PE-wide output vector per completed output-channel group.
- Consumes the control unit's do_mvau_stream and sf_clr, re-aligned internally to the datapath latency.

Parameters:
- PE, 2, number of processing elements (output lanes)
- SF, 8, SIMD chunks per dot product; SF >= 1
- DP_W, 16, signed width of each per-PE partial dot product from the adder tree
- TO, 24, signed width of each accumulator and output lane; TO >= DP_W
- MUL_LAT, 2, pipeline latency of the multiply/adder-tree stage in cycles; 0 allowed

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high
- do_mvau_stream  in  1  control valid: a chunk enters the multiply stage this cycle
- sf_clr  in  1  control: this chunk is the last (SF-1) of a dot product
- dp_in  in  PE*DP_W  per-PE signed partial products; lane p at [p*DP_W +: DP_W]; valid MUL_LAT cycles after the matching do_mvau_stream
- out_v  out  1  output valid, single-cycle pulse per completed vector
- out  out  PE*TO  per-PE accumulated results; lane p at [p*TO +: TO]
- err  out  1  sticky framing error

Behaviour:
- Alignment:
  - do_mvau_stream and sf_clr are delayed MUL_LAT cycles by a shift register, giving v_d and last_d.
  - MUL_LAT=0: v_d and last_d are the inputs directly.
  - dp_in is sampled only when v_d=1.
- Accumulation, per lane, on v_d=1:
  - first=1: acc <= sext(dp)
  - otherwise: acc <= acc + sext(dp)
  - Arithmetic is two's complement modulo 2^TO (wraps; no saturation).
  - dp is sign-extended from DP_W to TO.
- Completion, when v_d=1 and last_d=1:
  - out <= the accumulated sum including this beat (acc + dp, or sext(dp) if first=1).
  - out_v <= 1 on the next cycle.
  - first <= 1.
  - Otherwise, on v_d=1, first <= 0.
- Output:
  - out_v is high for exactly one cycle per completion.
  - out holds its value until the next completion.
  - Latency: last chunk at do_mvau_stream, cycle t, gives out_v at cycle t+MUL_LAT+1.
- Gaps:
  - v_d=0 freezes acc, first and the beat counter.
  - Gaps of any length between beats are allowed.
- Beat counter, width max(1,$clog2(SF)), counts accepted beats within a dot product.
  - Wraps to 0 on completion.
  - err is set (sticky until rst) if:
    - last_d=1 with v_d=1 and the counter is not SF-1, or
    - the counter is SF-1 with v_d=1 and last_d=0.
  - On an error, the completion or accumulation still proceeds as specified (the data path is not blocked).
- SF=1: every valid beat completes; out = sext(dp); err never sets on correct input.
- Back-to-back vectors: a completion beat immediately followed by a valid beat starts a fresh accumulation. No bubble is required.
- Reset, rst=1 at a clock edge:
  - out_v=0, out=0, err=0, all acc=0, first=1, beat counter=0.
  - Delay-line contents cleared to 0.
  - In-flight beats are discarded.
  - Reset mid-accumulation never produces out_v.
- No backpressure: the consumer must accept out every out_v cycle.

Decomposition:
- Shared package mvau_defn: acc lane typedef (logic signed [TO-1:0]) and a sign-extension function.
- One natural sub-module: mvau_stream_acc_lane, one PE lane accumulator (acc, sign-extend, add, output register), instanced PE times by generate.
- Delay line, beat counter, first flag and err stay in the top.

Test Plan:
- PE=2, SF=4, MUL_LAT=2: four consecutive beats of lane0 dp = 1,2,3,4 and lane1 dp = -1,-1,-1,-1, with sf_clr on beat 4 -> out_v one pulse 3 cycles after the beat-4 control; out lane0=10, lane1=-4; err=0.
- Same config, two vectors back-to-back (8 beats, no gap): second vector lane0 = 5,5,5,5 -> out_v pulses 4 cycles apart; second out lane0=20; no carry-over from vector 1.
- Gaps: beats separated by 0–3 idle cycles of do_mvau_stream=0 -> same sums as the gapless case; out_v count=1 per vector.
- Wrap: TO=DP_W=8, SF=2, dp=127 twice -> out lane = -2 (8'hFE).
- Framing: sf_clr asserted on beat 2 of SF=4 -> err=1 and stays 1 through later correct vectors; rst clears it to 0.
- Reset mid-vector after 2 of 4 beats, then a clean 4-beat vector of 1s -> no out_v during reset; next out = 4; out=0 during reset.
